// File: rtl/ddr_rx_pkg.sv
// Shared types and defaults for the DDR receive word aligner.
package ddr_rx_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int          DEF_WORD_W    = 8;
    localparam logic [15:0] DEF_TRAIN_PAT = 16'h0035;

    // Width of the slip (bit offset) field for a given word width.
    function automatic int slip_width(input int word_w);
        return $clog2(word_w);
    endfunction

endpackage

// File: rtl/ddr_rx_gearbox.sv
// Collects IDDR bit pairs into a two-word window, tracks word phase and
// presents the candidate word at the current slip offset.
module ddr_rx_gearbox
    import ddr_rx_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int SW     = slip_width(DEF_WORD_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              q0,
    input  logic              q1,
    input  logic [SW-1:0]     slip,
    output logic [WORD_W-1:0] cand,
    output logic              bnd
);

    localparam int              PH_W    = (WORD_W / 2 > 1) ? $clog2(WORD_W / 2) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(WORD_W / 2 - 1);

    logic [2*WORD_W-1:0] window;
    logic [2*WORD_W-1:0] shifted;
    logic [PH_W-1:0]     ph;

    // Shift in the rising-edge bit first so the oldest bit sits at the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window <= '0;
        end else begin
            window <= {window[2*WORD_W-3:0], q0, q1};
        end
    end

    // Pair counter; bnd marks the cycle after the last pair of a word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph  <= '0;
            bnd <= 1'b0;
        end else begin
            bnd <= (ph == PH_LAST);
            if (ph == PH_LAST) begin
                ph <= '0;
            end else begin
                ph <= ph + 1'b1;
            end
        end
    end

    // Candidate word starts slip bits below the window MSB.
    always_comb begin
        shifted = window << slip;
        cand    = shifted[2*WORD_W-1 -: WORD_W];
    end

endmodule

// File: rtl/ddr_rx_word_aligner.sv
// Word aligner: bit-slips the gearbox until the training word is seen
// LOCK_CNT times in a row, then streams aligned words with a valid strobe.
module ddr_rx_word_aligner
    import ddr_rx_pkg::*;
#(
    parameter int                WORD_W    = DEF_WORD_W,
    parameter logic [WORD_W-1:0] TRAIN_PAT = DEF_TRAIN_PAT[WORD_W-1:0],
    parameter int                LOCK_CNT  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      q0,
    input  logic                      q1,
    input  logic                      realign,
    output logic [WORD_W-1:0]         word_out,
    output logic                      word_valid,
    output logic                      locked,
    output logic [$clog2(WORD_W)-1:0] slip,
    output logic                      align_fail
);

    localparam int            SW        = slip_width(WORD_W);
    localparam logic [SW-1:0] SLIP_LAST = SW'(WORD_W - 1);
    localparam logic [3:0]    LOCK_LAST = 4'(LOCK_CNT);

    state_t              state, state_nx;
    logic [3:0]          cnt, cnt_nx;
    logic [SW-1:0]       slip_nx, slip_inc;
    logic                fail_nx;
    logic                wrap;
    logic                match;
    logic                valid_nx;
    logic [WORD_W-1:0]   cand;
    logic                bnd;

    ddr_rx_gearbox #(
        .WORD_W (WORD_W),
        .SW     (SW)
    ) u_gearbox (
        .clk   (clk),
        .rst_n (rst_n),
        .q0    (q0),
        .q1    (q1),
        .slip  (slip),
        .cand  (cand),
        .bnd   (bnd)
    );

    // State, match count, slip, sticky fail flag and output word registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SEARCH;
            cnt        <= '0;
            slip       <= '0;
            align_fail <= 1'b0;
            word_out   <= '0;
            word_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            slip       <= slip_nx;
            align_fail <= fail_nx;
            word_valid <= valid_nx;
            if (bnd) begin
                word_out <= cand;
            end
        end
    end

    // Next-state logic: realign overrides any boundary action.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        slip_nx  = slip;
        fail_nx  = align_fail;
        wrap     = (slip == SLIP_LAST);
        slip_inc = wrap ? '0 : slip + 1'b1;
        match    = (cand == TRAIN_PAT);
        valid_nx = bnd && (state == LOCKED) && !realign;

        if (realign) begin
            state_nx = SEARCH;
            cnt_nx   = '0;
            fail_nx  = 1'b0;
        end else if (bnd) begin
            case (state)
                SEARCH: begin
                    if (match) begin
                        cnt_nx   = 4'd1;
                        state_nx = (LOCK_CNT == 1) ? LOCKED : VERIFY;
                    end else begin
                        slip_nx = slip_inc;
                        if (wrap) fail_nx = 1'b1;
                    end
                end
                VERIFY: begin
                    if (match) begin
                        cnt_nx = cnt + 1'b1;
                        if (cnt + 1'b1 == LOCK_LAST) state_nx = LOCKED;
                    end else begin
                        state_nx = SEARCH;
                        cnt_nx   = '0;
                        slip_nx  = slip_inc;
                        if (wrap) fail_nx = 1'b1;
                    end
                end
                LOCKED: begin
                end
                default: begin
                    state_nx = SEARCH;
                end
            endcase
        end
    end

    assign locked = (state == LOCKED);

endmodule
